// File: rtl/vc_drain_arbiter_if.sv
// Handshake bundle between the VC drain arbiter, its two upstream VC FIFOs
// and its two downstream destination FIFOs.
interface vc_drain_arbiter_if #(
   parameter int BW = 6
);
   logic          pause;
   logic          vc0_empty;
   logic          vc1_empty;
   logic [BW-1:0] vc0_data;
   logic [BW-1:0] vc1_data;
   logic          d0_almost_full;
   logic          d1_almost_full;
   logic          vc0_rd;
   logic          vc1_rd;
   logic          d0_wr;
   logic          d1_wr;
   logic [BW-1:0] data_out;
   logic          holding;
   logic [7:0]    fwd_count;

   modport master (
      output pause, vc0_empty, vc1_empty, vc0_data, vc1_data,
      output d0_almost_full, d1_almost_full,
      input  vc0_rd, vc1_rd, d0_wr, d1_wr, data_out, holding, fwd_count
   );

   modport slave (
      input  pause, vc0_empty, vc1_empty, vc0_data, vc1_data,
      input  d0_almost_full, d1_almost_full,
      output vc0_rd, vc1_rd, d0_wr, d1_wr, data_out, holding, fwd_count
   );
endinterface

// File: rtl/vc_drain_arbiter.sv
// Drains two prioritised VC FIFOs through a one-word holding register into
// two destination FIFOs, with a starvation limiter protecting VC1.
module vc_drain_arbiter #(
   parameter int BW         = 6,
   parameter int DEST_BIT   = 5,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               reset_L,
   vc_drain_arbiter_if.slave bus
);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   typedef enum logic {S_EMPTY, S_FULL} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] word_q, word_d;
   logic [3:0]    starve_q, starve_d;
   logic [7:0]    fwd_q, fwd_d;
   logic          dest, wr_fire, accept, force1, g0, g1;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= S_EMPTY;
         word_q   <= '0;
         starve_q <= '0;
         fwd_q    <= '0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         starve_q <= starve_d;
         fwd_q    <= fwd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      starve_d = starve_q;
      fwd_d    = fwd_q;
      dest     = word_q[DEST_BIT];
      wr_fire  = (state_q == S_FULL) &
                 !(dest ? bus.d1_almost_full : bus.d0_almost_full);
      // Read strobes are combinational, so hold them off while in reset
      accept   = reset_L & !bus.pause &
                 ((state_q == S_EMPTY) | wr_fire);
      force1   = (starve_q == SMAX) & !bus.vc1_empty;
      g0       = accept & !bus.vc0_empty & !force1;
      g1       = accept & !bus.vc1_empty & !g0;
      unique case (state_q)
         S_EMPTY: if (g0 | g1) state_d = S_FULL;
         S_FULL:  if (wr_fire & !(g0 | g1)) state_d = S_EMPTY;
      endcase
      if (g0) word_d = bus.vc0_data;
      else if (g1) word_d = bus.vc1_data;
      if (bus.vc1_empty | g1) starve_d = '0;
      else if (g0) starve_d = starve_q + 4'd1;
      if (wr_fire) fwd_d = fwd_q + 8'd1;
   end

   assign bus.vc0_rd    = g0;
   assign bus.vc1_rd    = g1;
   assign bus.d0_wr     = wr_fire & !dest;
   assign bus.d1_wr     = wr_fire & dest;
   assign bus.data_out  = wr_fire ? word_q : '0;
   assign bus.holding   = (state_q == S_FULL);
   assign bus.fwd_count = fwd_q;
endmodule
